// File: rtl/ripple_carry_adder_16bit_if.sv
// Operand/result bundle for the registered ripple-carry adder.
// The producer drives in1/in2/c_in and the adder returns sum/c_out one clock later.
interface ripple_carry_adder_16bit_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] in1;
   logic [WIDTH-1:0] in2;
   logic             c_in;
   logic [WIDTH-1:0] sum;
   logic             c_out;

   modport master (
      output in1,
      output in2,
      output c_in,
      input  sum,
      input  c_out
   );

   modport slave (
      input  in1,
      input  in2,
      input  c_in,
      output sum,
      output c_out
   );
endinterface

// File: rtl/ripple_carry_adder_16bit.sv
// Registered unsigned adder: a WIDTH-stage ripple chain of 1-bit full adders
// whose sum and carry-out are captured every rising edge (sync active-high reset).
module ripple_carry_adder_16bit #(
   parameter int WIDTH = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   ripple_carry_adder_16bit_if.slave      bus
);

   // There is no handshake: every rising edge captures the current operands,
   // and the result is held on sum/c_out until the next edge.

   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum_comb;

   assign carry[0] = bus.c_in;

   // carry[0] -> carry[WIDTH] is the critical path that bounds the clock rate.
   for (genvar i = 0; i < WIDTH; i++) begin : g_stage
      logic half;
      assign half         = bus.in1[i] ^ bus.in2[i];
      assign sum_comb[i]  = half ^ carry[i];
      assign carry[i+1]   = (bus.in1[i] & bus.in2[i]) | (carry[i] & half);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.sum   <= '0;
         bus.c_out <= 1'b0;
      end else begin
         bus.sum   <= sum_comb;
         bus.c_out <= carry[WIDTH];
      end
   end

endmodule

// File: tb/tb_ripple_carry_adder_16bit.sv
// Scoreboard bench for the registered ripple-carry adder: driver pushes expected
// {c_out,sum} per vector, monitor pops and compares one clock later.
module tb_ripple_carry_adder_16bit;

   localparam int W = 16;

   logic clk;
   logic rst;

   ripple_carry_adder_16bit_if #(.WIDTH(W)) bus ();

   ripple_carry_adder_16bit #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [W:0] exp_q[$];
   int         id_q[$];
   int         tests = 0;
   int         fails = 0;
   int         vec_id = 0;

   task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic r, input logic [W:0] e);
      @(negedge clk);
      bus.in1  = a;
      bus.in2  = b;
      bus.c_in = c;
      rst      = r;
      exp_q.push_back(e);
      id_q.push_back(vec_id);
      vec_id++;
   endtask

   always @(posedge clk) begin
      logic [W:0] e;
      int         id;
      #1;
      if (exp_q.size() > 0) begin
         e  = exp_q.pop_front();
         id = id_q.pop_front();
         tests++;
         if ({bus.c_out, bus.sum} !== e) begin
            fails++;
            $display("FAIL vec%0d: got c_out=%0b sum=%h, expected c_out=%0b sum=%h",
                     id, bus.c_out, bus.sum, e[W], e[W-1:0]);
         end
      end
   end

   initial begin
      logic [W-1:0] a, b;
      logic         c;
      logic [W:0]   ref_sum;

      rst      = 1'b1;
      bus.in1  = '0;
      bus.in2  = '0;
      bus.c_in = 1'b0;

      // Reset dominates even the largest operands
      drive(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 17'h00000);
      drive(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 17'h00000);
      drive(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 17'h1FFFE);

      drive(16'd16245, 16'd3785,  1'b0, 1'b0, 17'd20030);
      drive(16'd3785,  16'd16245, 1'b1, 1'b0, 17'd20031);
      drive(16'd65005, 16'd530,   1'b0, 1'b0, 17'd65535);
      drive(16'd25531, 16'd40005, 1'b0, 1'b0, 17'h10000);
      drive(16'd40006, 16'd25530, 1'b1, 1'b0, 17'h10001);
      drive(16'hFFFF,  16'h0000,  1'b1, 1'b0, 17'h10000);
      drive(16'hAAAA,  16'h5555,  1'b0, 1'b0, 17'h0FFFF);
      drive(16'hFFFF,  16'hFFFF,  1'b1, 1'b0, 17'h1FFFF);
      drive(16'h8000,  16'h8000,  1'b0, 1'b0, 17'h10000);

      // Mid-stream reset: operands keep changing, one edge with rst high
      drive(16'h1234, 16'h4321, 1'b0, 1'b0, 17'h05555);
      drive(16'hF000, 16'h1000, 1'b1, 1'b1, 17'h00000);
      drive(16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 17'h10000);
      drive(16'h0001, 16'h0002, 1'b0, 1'b0, 17'h00003);

      // A reset pulse between edges must not disturb the held result
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      tests++;
      if ({bus.c_out, bus.sum} !== 17'h00003) begin
         fails++;
         $display("FAIL async_rst: got c_out=%0b sum=%h, expected c_out=0 sum=0003",
                  bus.c_out, bus.sum);
      end
      rst = 1'b0;

      for (int i = 0; i < 1000; i++) begin
         a = W'($urandom_range(0, 65535));
         b = W'($urandom_range(0, 65535));
         c = 1'($urandom_range(0, 1));
         ref_sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
         drive(a, b, c, 1'b0, ref_sum);
      end

      repeat (3) @(posedge clk);
      #2;
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d results pending, expected 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
